// File: rtl/axil_mailbox_pkg.sv
// Shared definitions for the mailbox register bank: register offsets,
// the empty-read marker word and sticky status bit positions.
package axil_mailbox_pkg;

    typedef enum logic [2:0] {
        REG_TX_DATA      = 3'd0,
        REG_TX_VACANCY   = 3'd1,
        REG_RX_DATA      = 3'd2,
        REG_RX_OCCUPANCY = 3'd3,
        REG_STATUS       = 3'd4
    } reg_offset_e;

    localparam logic [31:0] RX_EMPTY_WORD = 32'hdead_beef;

    localparam int unsigned STAT_TX_OVF = 0;
    localparam int unsigned STAT_RX_UNF = 1;

endpackage

// File: rtl/mailbox_fifo.sv
// 1r1w FIFO with valid/ready on both sides; a push into a full FIFO is
// accepted when it coincides with a pop.
module mailbox_fifo #(
    parameter int unsigned els_p        = 16,
    parameter int unsigned width_p      = 32,
    parameter int unsigned cnt_width_lp = $clog2(els_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    v_i,
    input  logic [width_p-1:0]      data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [width_p-1:0]      data_o,
    input  logic                    ready_i,
    output logic [cnt_width_lp-1:0] count_o
);

    localparam int unsigned ptr_width_lp = $clog2(els_p);

    logic [width_p-1:0]      mem_q [els_p];
    logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic                    push, pop;

    assign ready_o = (count_q != cnt_width_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign pop     = v_o && ready_i;
    assign push    = v_i && (ready_o || pop);
    assign count_o = count_q;
    // Head is masked while empty so the output is defined from reset.
    assign data_o  = v_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + ptr_width_lp'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ptr_width_lp'(1);
        if (push && !pop)      count_d = count_q + cnt_width_lp'(1);
        else if (pop && !push) count_d = count_q - cnt_width_lp'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/axil_mailbox_regs.sv
// Mailbox register bank behind the AXI-Lite bridge: TX/RX FIFOs, occupancy
// registers and sticky W1C error status, one side effect per strobe.
module axil_mailbox_regs
    import axil_mailbox_pkg::*;
#(
    parameter int unsigned mem_addr_width_p = 8,
    parameter int unsigned els_p            = 16,
    parameter int unsigned cnt_width_lp     = $clog2(els_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [mem_addr_width_p-1:0] addr_i,
    input  logic                        wen_i,
    input  logic [31:0]                 data_i,
    input  logic                        ren_i,
    output logic [31:0]                 data_o,
    output logic                        tx_v_o,
    output logic [31:0]                 tx_data_o,
    input  logic                        tx_ready_i,
    input  logic                        rx_v_i,
    input  logic [31:0]                 rx_data_i,
    output logic                        rx_ready_o
);

    logic                    wen_q, ren_q;
    logic [31:0]             rdata_q, rdata_d;
    logic [1:0]              status_q, status_d, status_set, status_clr;
    logic                    wr_start, rd_start;
    reg_offset_e             off;
    logic                    tx_push, tx_pop, tx_not_full;
    logic                    rx_pop, rx_v;
    logic [31:0]             rx_head;
    logic [cnt_width_lp-1:0] tx_count, rx_count;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{addr_i[mem_addr_width_p-1:5], addr_i[1:0]};

    assign wr_start = wen_i && !wen_q;
    assign rd_start = ren_i && !ren_q;
    assign off      = reg_offset_e'(addr_i[4:2]);
    assign tx_pop   = tx_v_o && tx_ready_i;

    always_comb begin
        tx_push    = 1'b0;
        rx_pop     = 1'b0;
        status_set = '0;
        status_clr = '0;
        rdata_d    = rdata_q;
        if (wr_start) begin
            case (off)
                REG_TX_DATA: begin
                    tx_push = 1'b1;
                    if (!tx_not_full && !tx_pop) status_set[STAT_TX_OVF] = 1'b1;
                end
                REG_STATUS: status_clr = data_i[1:0];
                default: ;
            endcase
            // A read colliding with a write is dropped and returns zero.
            if (rd_start) rdata_d = '0;
        end else if (rd_start) begin
            case (off)
                REG_TX_VACANCY:   rdata_d = 32'(cnt_width_lp'(els_p) - tx_count);
                REG_RX_DATA: begin
                    if (rx_v) begin
                        rx_pop  = 1'b1;
                        rdata_d = rx_head;
                    end else begin
                        rdata_d = RX_EMPTY_WORD;
                        status_set[STAT_RX_UNF] = 1'b1;
                    end
                end
                REG_RX_OCCUPANCY: rdata_d = 32'(rx_count);
                REG_STATUS:       rdata_d = 32'(status_q);
                default:          rdata_d = '0;
            endcase
        end
        status_d = (status_q & ~status_clr) | status_set;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wen_q    <= 1'b1;
            ren_q    <= 1'b1;
            rdata_q  <= '0;
            status_q <= '0;
        end else begin
            wen_q    <= wen_i;
            ren_q    <= ren_i;
            rdata_q  <= rdata_d;
            status_q <= status_d;
        end
    end

    assign data_o = rdata_q;

    mailbox_fifo #(.els_p(els_p), .width_p(32), .cnt_width_lp(cnt_width_lp)) tx_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (tx_push),
        .data_i  (data_i),
        .ready_o (tx_not_full),
        .v_o     (tx_v_o),
        .data_o  (tx_data_o),
        .ready_i (tx_ready_i),
        .count_o (tx_count)
    );

    mailbox_fifo #(.els_p(els_p), .width_p(32), .cnt_width_lp(cnt_width_lp)) rx_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (rx_v_i),
        .data_i  (rx_data_i),
        .ready_o (rx_ready_o),
        .v_o     (rx_v),
        .data_o  (rx_head),
        .ready_i (rx_pop),
        .count_o (rx_count)
    );

endmodule

// File: tb/tb_axil_mailbox_regs.sv
// Scoreboard bench for axil_mailbox_regs: a queue-based mailbox model predicts
// read data and TX heads; a negedge monitor compares them as they appear.
module tb_axil_mailbox_regs;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] DEAD  = 32'hdead_beef;

    logic        clk, rst;
    logic [7:0]  addr;
    logic        wen, ren;
    logic [31:0] wdata;
    logic [31:0] data_o;
    logic        tx_v_o;
    logic [31:0] tx_data_o;
    logic        tx_ready;
    logic        rx_v;
    logic [31:0] rx_data;
    logic        rx_ready_o;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    logic [31:0] exp_rd_q[$];
    logic [31:0] tx_m[$];
    logic [31:0] rx_m[$];
    logic [1:0]  st_m;
    logic        rd_chk;

    axil_mailbox_regs #(.mem_addr_width_p(8), .els_p(DEPTH)) dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .addr_i     (addr),
        .wen_i      (wen),
        .data_i     (wdata),
        .ren_i      (ren),
        .data_o     (data_o),
        .tx_v_o     (tx_v_o),
        .tx_data_o  (tx_data_o),
        .tx_ready_i (tx_ready),
        .rx_v_i     (rx_v),
        .rx_data_i  (rx_data),
        .rx_ready_o (rx_ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (rd_chk) begin
            if (exp_rd_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rd_data: got %h with no expected entry", data_o);
            end else begin
                e = exp_rd_q.pop_front();
                check("rd_data", data_o, e);
            end
        end
        if (!rst && tx_v_o && tx_ready) begin
            if (tx_m.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL tx_head: got %h but model TX is empty", tx_data_o);
            end else begin
                e = tx_m.pop_front();
                check("tx_head", tx_data_o, e);
            end
        end
    end

    function automatic logic [7:0] mk_addr(input logic [2:0] off);
        logic [2:0] hi;
        logic [1:0] lo;
        hi = 3'($urandom);
        lo = 2'($urandom);
        return {hi, off, lo};
    endfunction

    task automatic bus_write(input logic [2:0] off, input logic [31:0] d);
        @(posedge clk); #1;
        case (off)
            3'd0: if (tx_m.size() < DEPTH) tx_m.push_back(d); else st_m[0] = 1'b1;
            3'd4: st_m = st_m & ~d[1:0];
            default: ;
        endcase
        addr = mk_addr(off); wdata = d; wen = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wen = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] off);
        logic [31:0] e;
        case (off)
            3'd1: e = DEPTH - tx_m.size();
            3'd2: begin
                if (rx_m.size() == 0) begin
                    e = DEAD;
                    st_m[1] = 1'b1;
                end else e = rx_m.pop_front();
            end
            3'd3: e = rx_m.size();
            3'd4: e = {30'b0, st_m};
            default: e = 32'h0;
        endcase
        return e;
    endfunction

    task automatic bus_read(input logic [2:0] off);
        @(posedge clk); #1;
        exp_rd_q.push_back(model_read(off));
        addr = mk_addr(off); ren = 1'b1;
        @(posedge clk); #1;
        rd_chk = 1'b1;
        @(posedge clk); #1;
        ren = 1'b0; rd_chk = 1'b0;
    endtask

    task automatic rx_push(input logic [31:0] d);
        @(posedge clk); #1;
        if (rx_m.size() < DEPTH) rx_m.push_back(d);
        rx_v = 1'b1; rx_data = d;
        @(posedge clk); #1;
        rx_v = 1'b0;
    endtask

    // RX_DATA read and RX push landing on the same edge (RX must be non-empty).
    task automatic rx_pop_push(input logic [31:0] d);
        @(posedge clk); #1;
        exp_rd_q.push_back(model_read(3'd2));
        if (rx_m.size() < DEPTH) rx_m.push_back(d);
        addr = mk_addr(3'd2); ren = 1'b1; rx_v = 1'b1; rx_data = d;
        @(posedge clk); #1;
        rx_v = 1'b0; rd_chk = 1'b1;
        @(posedge clk); #1;
        ren = 1'b0; rd_chk = 1'b0;
    endtask

    task automatic drain(input int unsigned n);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1 tx_ready = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] r;
        rst = 1'b1; addr = '0; wen = 1'b0; ren = 1'b0; wdata = '0;
        tx_ready = 1'b0; rx_v = 1'b0; rx_data = '0; rd_chk = 1'b0; st_m = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset data_o", data_o, 32'h0);
        check("reset tx_v_o", 32'(tx_v_o), 32'h0);
        check("reset tx_data_o", tx_data_o, 32'h0);
        check("reset rx_ready_o", 32'(rx_ready_o), 32'h1);
        rst = 1'b0;

        // TX basic
        bus_write(3'd0, 32'd1);
        bus_write(3'd0, 32'd2);
        bus_write(3'd0, 32'd3);
        check("tx_v after writes", 32'(tx_v_o), 32'h1);
        check("tx_data after writes", tx_data_o, 32'd1);
        bus_read(3'd1);
        drain(3);
        check("tx_v after drain", 32'(tx_v_o), 32'h0);

        // RX single word, then occupancy
        rx_push(32'ha5a5_0001);
        bus_read(3'd2);
        bus_read(3'd3);

        // Underflow and W1C
        bus_read(3'd2);
        bus_read(3'd4);
        bus_write(3'd4, 32'd2);
        bus_read(3'd4);

        // TX overflow
        for (int unsigned i = 0; i < DEPTH + 1; i++) bus_write(3'd0, 32'h100 + i);
        bus_read(3'd4);
        bus_read(3'd1);
        drain(DEPTH);
        check("tx_v after full drain", 32'(tx_v_o), 32'h0);
        bus_write(3'd4, 32'h3);
        bus_read(3'd4);

        // RX full, then pop+push on the same edge
        for (int unsigned i = 0; i < DEPTH; i++) rx_push(32'h200 + i);
        check("rx_ready when full", 32'(rx_ready_o), 32'h0);
        rx_pop_push(32'h2ff);
        bus_read(3'd3);
        check("rx_ready still full", 32'(rx_ready_o), 32'h0);
        for (int unsigned i = 0; i < DEPTH; i++) bus_read(3'd2);
        bus_read(3'd3);

        // Reset in the middle of a read strobe
        for (int unsigned i = 0; i < 3; i++) rx_push(32'h300 + i);
        bus_read(3'd3);
        @(posedge clk); #1;
        addr = 8'h08; ren = 1'b1; rst = 1'b1;
        rx_m.delete(); tx_m.delete(); st_m = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 ren = 1'b0;
        check("data_o after mid reset", data_o, 32'h0);
        check("rx_ready after mid reset", 32'(rx_ready_o), 32'h1);
        bus_read(3'd3);
        bus_read(3'd4);

        // Randomized traffic
        for (int unsigned n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: bus_write(3'd0, $urandom);
                3, 4, 5: bus_read(3'($urandom_range(0, 7)));
                6, 7:    rx_push($urandom);
                8:       drain($urandom_range(1, 4));
                default: bus_write(3'($urandom_range(1, 7)), $urandom);
            endcase
        end
        check("final tx_v", 32'(tx_v_o), 32'(tx_m.size() != 0));
        check("final rx_ready", 32'(rx_ready_o), 32'(rx_m.size() < DEPTH));
        bus_read(3'd1);
        bus_read(3'd3);
        bus_read(3'd4);
        @(posedge clk); #1;
        check("scoreboard drained", 32'(exp_rd_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
